// File: rtl/ball_motion_ctrl_if.sv
// Signal bundle between the ball motion controller and the collision checker.
// master = ball controller side, slave = collision checker / stimulus side.
interface ball_motion_ctrl_if;
    logic       GameEnable;
    logic [2:0] ColOut;
    logic [9:0] ballSpeed;
    logic [1:0] LivesCount;
    logic [9:0] ballPosX;
    logic [9:0] ballPosY;
    logic       dirX;
    logic       dirY;
    logic       ballPosReset;
    logic       GameOver;
    logic [1:0] State;

    modport master (
        input  GameEnable, ColOut, ballSpeed, LivesCount,
        output ballPosX, ballPosY, dirX, dirY, ballPosReset, GameOver, State
    );

    modport slave (
        output GameEnable, ColOut, ballSpeed, LivesCount,
        input  ballPosX, ballPosY, dirX, dirY, ballPosReset, GameOver, State
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// PONG ball motion: per-frame-tick position stepping, collision reflection and serve/miss/over sequencing.
// Optional macro RANDOM_SERVE_EN: serve direction taken from a free-running 16-bit LFSR.
module ball_motion_ctrl #(
    parameter int TICK_DIV    = 1666667,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int START_X     = 320,
    parameter int START_Y     = 240,
    parameter int SERVE_TICKS = 60,
    parameter int MISS_TICKS  = 30,
    parameter int MAX_STEP    = 8
) (
    input  logic                 Clk_100MHz,
    input  logic                 Reset,
    ball_motion_ctrl_if.master   bus
);
    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PMX = (SERVE_TICKS > MISS_TICKS) ? SERVE_TICKS : MISS_TICKS;
    localparam int PCW = $clog2(PMX + 1);
    localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV - 1);
    localparam logic [PCW-1:0] SERVE_LAST = PCW'(SERVE_TICKS - 1);
    localparam logic [PCW-1:0] MISS_LAST  = PCW'(MISS_TICKS - 1);
    localparam logic [9:0] X_MAX = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0] Y_MAX = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] X0    = 10'(START_X);
    localparam logic [9:0] Y0    = 10'(START_Y);
    localparam logic [9:0] STEP_MAX = 10'(MAX_STEP);

    // OVER shares debug code 3 with MISS, so the internal encoding needs a fifth value
    typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, MOVE = 3'd2, MISS = 3'd3, OVER = 3'd4} state_t;

    state_t         state, state_nx;
    logic [TCW-1:0] tcnt;
    logic           tick;
    logic [4:0]     flags, col_set;   // [0] top [1] bottom [2] right [3] paddle [4] miss
    logic [PCW-1:0] pcnt, pcnt_nx;
    logic [9:0]     x, y, x_nx, y_nx, x_mv, y_mv, step;
    logic [10:0]    x_sum, y_sum;
    logic           dx, dy, dx_nx, dy_nx, dx_ref, dy_ref, pr, pr_nx;
    logic           serve_dx, serve_dy, recentre;

    assign tick = (tcnt == TICK_LAST);

    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) tcnt <= '0;
        else        tcnt <= tick ? '0 : tcnt + TCW'(1);
    end

    always_comb begin
        col_set = '0;
        if (bus.ColOut inside {[3'd1:3'd5]}) col_set = 5'b1 << (bus.ColOut - 3'd1);
    end

    // A code arriving on the tick cycle survives into the next interval
    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) flags <= '0;
        else        flags <= tick ? col_set : (flags | col_set);
    end

`ifdef RANDOM_SERVE_EN
    logic [15:0] lfsr;
    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign serve_dx = lfsr[1];
    assign serve_dy = lfsr[0];
`else
    assign serve_dx = 1'b0;
    assign serve_dy = 1'b1;
`endif

    always_comb begin
        step = bus.ballSpeed;
        if (bus.ballSpeed == 10'd0)   step = 10'd1;
        else if (bus.ballSpeed > STEP_MAX) step = STEP_MAX;

        dx_ref = dx;
        if (flags[3] && !flags[2])      dx_ref = 1'b1;
        else if (flags[2] && !flags[3]) dx_ref = 1'b0;
        dy_ref = dy;
        if (flags[0] && flags[1]) dy_ref = ~dy;
        else if (flags[0])        dy_ref = 1'b1;
        else if (flags[1])        dy_ref = 1'b0;

        x_sum = {1'b0, x} + {1'b0, step};
        y_sum = {1'b0, y} + {1'b0, step};
        if (dx_ref) x_mv = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];
        else        x_mv = (x < step) ? 10'd0 : x - step;
        if (dy_ref) y_mv = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[9:0];
        else        y_mv = (y < step) ? 10'd0 : y - step;
    end

    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            pcnt  <= '0;
            x     <= X0;
            y     <= Y0;
            dx    <= 1'b0;
            dy    <= 1'b1;
            pr    <= 1'b0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            x     <= x_nx;
            y     <= y_nx;
            dx    <= dx_nx;
            dy    <= dy_nx;
            pr    <= pr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        x_nx     = x;
        y_nx     = y;
        dx_nx    = dx;
        dy_nx    = dy;
        pr_nx    = 1'b0;
        recentre = 1'b0;
        case (state)
            IDLE: if (bus.GameEnable) begin
                state_nx = SERVE;
                pcnt_nx  = '0;
                recentre = 1'b1;
                pr_nx    = 1'b1;
            end
            SERVE: if (!bus.GameEnable) begin
                state_nx = IDLE;
                recentre = 1'b1;
            end else if (tick) begin
                if (pcnt == SERVE_LAST) begin
                    state_nx = MOVE;
                    pcnt_nx  = '0;
                end else pcnt_nx = pcnt + PCW'(1);
            end
            MOVE: if (!bus.GameEnable) begin
                state_nx = IDLE;
                recentre = 1'b1;
            end else if (tick) begin
                if (flags[4]) begin
                    state_nx = MISS;
                    pcnt_nx  = '0;
                end else begin
                    x_nx  = x_mv;
                    y_nx  = y_mv;
                    dx_nx = dx_ref;
                    dy_nx = dy_ref;
                end
            end
            MISS: if (!bus.GameEnable) begin
                state_nx = IDLE;
                recentre = 1'b1;
            end else if (tick) begin
                if (pcnt == MISS_LAST) begin
                    pcnt_nx = '0;
                    if (bus.LivesCount == 2'd0) state_nx = OVER;
                    else begin
                        state_nx = SERVE;
                        recentre = 1'b1;
                        pr_nx    = 1'b1;
                    end
                end else pcnt_nx = pcnt + PCW'(1);
            end
            OVER: if (!bus.GameEnable) begin
                state_nx = IDLE;
                recentre = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (recentre) begin
            x_nx  = X0;
            y_nx  = Y0;
            dx_nx = serve_dx;
            dy_nx = serve_dy;
        end
    end

    assign bus.ballPosX     = x;
    assign bus.ballPosY     = y;
    assign bus.dirX         = dx;
    assign bus.dirY         = dy;
    assign bus.ballPosReset = pr;
    assign bus.GameOver     = (state == OVER);
    assign bus.State        = (state == OVER) ? 2'd3 : state[1:0];
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: behavioural game model compared every cycle plus directed literal checks.
module tb_ball_motion_ctrl;
    localparam int TICK_DIV = 4, SERVE_TICKS = 2, MISS_TICKS = 3;
    localparam int XMAX = 632, YMAX = 472;

    logic clk = 1'b0, rst_n = 1'b0;
    int   n_cmp = 0, n_err = 0;
    ball_motion_ctrl_if bus();

    ball_motion_ctrl #(.TICK_DIV(TICK_DIV), .SERVE_TICKS(SERVE_TICKS), .MISS_TICKS(MISS_TICKS))
        dut (.Clk_100MHz(clk), .Reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 serve, 2 move, 3 miss, 4 over
    int m_cnt, m_ph, m_x, m_y, m_ticks;
    bit m_dx, m_dy, m_pr;
    bit [7:0] m_pend;
    logic [15:0] m_lfsr;

    function automatic int clamp_step(int s);
        return (s == 0) ? 1 : ((s > 8) ? 8 : s);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_ph = 0; m_x = 320; m_y = 240; m_ticks = 0;
            m_dx = 0; m_dy = 1; m_pr = 0; m_pend = '0; m_lfsr = 16'hACE1;
        end else begin
            bit tk, rc;
            bit [7:0] p;
            int st;
            tk = (m_cnt == TICK_DIV - 1);
            m_cnt = (m_cnt + 1) % TICK_DIV;
            p = m_pend;
            if (tk) m_pend = '0;
            if (bus.ColOut >= 3'd1 && bus.ColOut <= 3'd5) m_pend[bus.ColOut] = 1'b1;
            rc = 0; m_pr = 0;
            if (!bus.GameEnable && m_ph >= 1 && m_ph <= 3) begin
                m_ph = 0; rc = 1;
            end else begin
                case (m_ph)
                    0: if (bus.GameEnable) begin m_ph = 1; m_ticks = 0; rc = 1; m_pr = 1; end
                    1: if (tk) begin
                        m_ticks++;
                        if (m_ticks == SERVE_TICKS) begin m_ph = 2; m_ticks = 0; end
                    end
                    2: if (tk) begin
                        if (p[5]) begin m_ph = 3; m_ticks = 0; end
                        else begin
                            if (p[1] && p[2]) m_dy = !m_dy;
                            else if (p[1]) m_dy = 1;
                            else if (p[2]) m_dy = 0;
                            if (p[3] != p[4]) m_dx = p[4];
                            st = clamp_step(int'(bus.ballSpeed));
                            m_x = m_dx ? ((m_x + st > XMAX) ? XMAX : m_x + st) : ((m_x - st < 0) ? 0 : m_x - st);
                            m_y = m_dy ? ((m_y + st > YMAX) ? YMAX : m_y + st) : ((m_y - st < 0) ? 0 : m_y - st);
                        end
                    end
                    3: if (tk) begin
                        m_ticks++;
                        if (m_ticks == MISS_TICKS) begin
                            m_ticks = 0;
                            if (bus.LivesCount == 2'd0) m_ph = 4;
                            else begin m_ph = 1; rc = 1; m_pr = 1; end
                        end
                    end
                    default: if (!bus.GameEnable) begin m_ph = 0; rc = 1; end
                endcase
            end
            if (rc) begin
                m_x = 320; m_y = 240;
`ifdef RANDOM_SERVE_EN
                m_dx = m_lfsr[1]; m_dy = m_lfsr[0];
`else
                m_dx = 0; m_dy = 1;
`endif
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            logic [25:0] act, exp;
            act = {bus.ballPosX, bus.ballPosY, bus.dirX, bus.dirY, bus.ballPosReset, bus.GameOver, bus.State};
            exp = {10'(m_x), 10'(m_y), m_dx, m_dy, m_pr, (m_ph == 4), (m_ph == 4) ? 2'd3 : 2'(m_ph)};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL model_cycle t=%0t got x=%0d y=%0d dx=%b dy=%b pr=%b go=%b st=%0d want %h (dut %h)",
                         $time, act[25:16], act[15:6], act[5], act[4], act[3], act[2], act[1:0], exp, act);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input int bound, input string nm);
        int n = 0;
        while (int'(bus.State) != s && n < bound) begin @(negedge clk); n++; end
        chk(nm, int'(bus.State), s);
    endtask

    task automatic wait_x_change(input int bound, input string nm);
        int n = 0;
        logic [9:0] x0 = bus.ballPosX;
        while (bus.ballPosX == x0 && n < bound) begin @(negedge clk); n++; end
        chk(nm, int'(n < bound), 1);
    endtask

    task automatic pulse_col(input logic [2:0] c);
        @(negedge clk); bus.ColOut = c;
        @(negedge clk); bus.ColOut = 3'd0;
    endtask

    initial begin
        int x0, n;
        bus.GameEnable = 0; bus.ColOut = 0; bus.ballSpeed = 3; bus.LivesCount = 2;
        repeat (3) @(negedge clk);
        chk("reset_x", bus.ballPosX, 320);  chk("reset_y", bus.ballPosY, 240);
        chk("reset_dx", bus.dirX, 0);       chk("reset_dy", bus.dirY, 1);
        chk("reset_pr", bus.ballPosReset, 0); chk("reset_go", bus.GameOver, 0);
        chk("reset_state", bus.State, 0);
        rst_n = 1;
        @(negedge clk); bus.GameEnable = 1;
        @(negedge clk); chk("serve_pulse", bus.ballPosReset, 1); chk("serve_state", bus.State, 1);
        @(negedge clk); chk("serve_pulse_end", bus.ballPosReset, 0);
        wait_state(2, 40, "enter_move");
        wait_x_change(20, "first_step_timeout");
        chk("first_x", bus.ballPosX, 317); chk("first_y", bus.ballPosY, 243);

        pulse_col(3'd4);
        x0 = bus.ballPosX;
        wait_x_change(20, "paddle_timeout");
        chk("paddle_dx", bus.dirX, 1); chk("paddle_x", bus.ballPosX, x0 + 3);

        bus.ballSpeed = 0; x0 = bus.ballPosX;
        wait_x_change(20, "speed0_timeout");
        chk("speed0_step", int'(bus.ballPosX) - x0, 1);
        bus.ballSpeed = 200; x0 = bus.ballPosX;
        wait_x_change(20, "speed200_timeout");
        chk("speed200_step", int'(bus.ballPosX) - x0, 8);

        bus.ballSpeed = 8;
        pulse_col(3'd3);
        n = 0;
        while (bus.ballPosX != 0 && n < 600) begin @(negedge clk); n++; end
        repeat (2 * TICK_DIV) @(negedge clk);
        chk("sat_x0", bus.ballPosX, 0);   chk("sat_dx", bus.dirX, 0);
        chk("sat_ymax", bus.ballPosY, YMAX); chk("sat_dy", bus.dirY, 1);

        repeat (1500) begin
            @(negedge clk);
            bus.ColOut = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
            if ($urandom_range(0, 15) == 0) bus.ballSpeed = 10'($urandom_range(0, 15));
        end
        @(negedge clk); bus.ColOut = 0;

        bus.LivesCount = 2;
        pulse_col(3'd5);
        wait_state(3, 20, "miss_state");
        x0 = bus.ballPosX;
        n = 0;
        while (!bus.ballPosReset && n < 60) begin @(negedge clk); n++; end
        chk("miss_recentre_pulse", bus.ballPosReset, 1);
        chk("miss_recentre_x", bus.ballPosX, 320); chk("miss_recentre_y", bus.ballPosY, 240);
        chk("miss_to_serve", bus.State, 1);
        wait_state(2, 40, "reenter_move");
        bus.LivesCount = 0;
        pulse_col(3'd5);
        n = 0;
        while (!bus.GameOver && n < 60) begin @(negedge clk); n++; end
        chk("over_flag", bus.GameOver, 1); chk("over_state", bus.State, 3);
        bus.GameEnable = 0;
        @(negedge clk);
        chk("over_to_idle", bus.State, 0); chk("idle_x", bus.ballPosX, 320);
        chk("idle_no_pulse", bus.ballPosReset, 0);

        bus.GameEnable = 1; bus.LivesCount = 2;
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) bus.GameEnable = ~bus.GameEnable;
            if ($urandom_range(0, 99) == 0) bus.LivesCount = 2'($urandom_range(0, 3));
            bus.ColOut = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            if ($urandom_range(0, 15) == 0) bus.ballSpeed = 10'($urandom_range(0, 300));
        end

        @(negedge clk); bus.GameEnable = 0; bus.ColOut = 0; bus.ballSpeed = 8; bus.LivesCount = 2;
        @(negedge clk); bus.GameEnable = 1;
        wait_state(2, 40, "pre_reset_move");
        pulse_col(3'd4);
        n = 0;
        while (bus.ballPosX < 400 && n < 200) begin @(negedge clk); n++; end
        chk("reach_400", int'(bus.ballPosX >= 400), 1);
        @(negedge clk); #2 rst_n = 0; #1;
        chk("midrst_x", bus.ballPosX, 320); chk("midrst_y", bus.ballPosY, 240);
        chk("midrst_dx", bus.dirX, 0);      chk("midrst_dy", bus.dirY, 1);
        chk("midrst_state", bus.State, 0);  chk("midrst_go", bus.GameOver, 0);
        chk("midrst_pr", bus.ballPosReset, 0);
        @(negedge clk); rst_n = 1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
